// File: rtl/mips_boot_pkg.sv
// Shared types and constants for the MIPS boot loader.
package mips_boot_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    HOLD   = 3'd2,
    RUN    = 3'd3,
    HALTED = 3'd4
  } boot_state_e;

  localparam int unsigned WORD_BYTES = 4;
  localparam logic [31:0] DEFAULT_HALT_ADDR = 32'h0000_FFFC;

endpackage

// File: rtl/imem_boot_loader.sv
// Boot sequencer: streams a program into instruction memory, runs the core, and
// catches the halt store that ends the program.
module imem_boot_loader
  import mips_boot_pkg::*;
#(
  parameter int unsigned MAX_WORDS = 256,
  parameter int unsigned RST_HOLD  = 4,
  parameter logic [31:0] HALT_ADDR = DEFAULT_HALT_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] word_count,
  input  logic        abort,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic        instwen,
  output logic [31:0] addwrite,
  output logic [31:0] instrdatain,
  output logic        cpu_reset,
  input  logic        memWrite,
  input  logic [31:0] Address,
  input  logic [31:0] writeData,
  output logic        busy,
  output logic        halted,
  output logic [31:0] exit_code,
  output logic        load_err
);

  localparam int unsigned IdxW  = $clog2(MAX_WORDS + 1);
  localparam int unsigned HoldW = $clog2(RST_HOLD + 1);

  boot_state_e      state_q, state_d;
  logic [IdxW-1:0]  index_q, index_d;
  logic [IdxW-1:0]  count_q, count_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             instwen_q, instwen_d;
  logic [31:0]      addwrite_q, addwrite_d;
  logic [31:0]      data_q, data_d;
  logic             cpu_reset_q, cpu_reset_d;
  logic [31:0]      exit_code_q, exit_code_d;
  logic             load_err_q, load_err_d;
  logic             accept;
  logic             bad_count;

  assign s_ready     = (state_q == LOAD);
  assign accept      = s_valid && s_ready;
  assign bad_count   = (word_count == 16'd0) || (32'(word_count) > MAX_WORDS);
  assign busy        = (state_q == LOAD) || (state_q == HOLD);
  assign halted      = (state_q == HALTED);
  assign instwen     = instwen_q;
  assign addwrite    = addwrite_q;
  assign instrdatain = data_q;
  assign cpu_reset   = cpu_reset_q;
  assign exit_code   = exit_code_q;
  assign load_err    = load_err_q;

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    count_d     = count_q;
    hold_d      = hold_q;
    instwen_d   = 1'b0;
    addwrite_d  = addwrite_q;
    data_d      = data_q;
    exit_code_d = exit_code_q;
    load_err_d  = load_err_q;

    if (abort) begin
      // Abort outranks everything, including a handshake in the same cycle.
      state_d     = IDLE;
      exit_code_d = 32'd0;
    end else begin
      unique case (state_q)
        IDLE, HALTED: begin
          if (start) begin
            if (bad_count) begin
              load_err_d = 1'b1;
            end else begin
              count_d     = IdxW'(word_count);
              index_d     = '0;
              load_err_d  = 1'b0;
              exit_code_d = 32'd0;
              state_d     = LOAD;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            instwen_d  = 1'b1;
            addwrite_d = 32'(index_q) * 32'(WORD_BYTES);
            data_d     = s_data;
            index_d    = index_q + IdxW'(1);
            if (index_q == count_q - IdxW'(1)) begin
              state_d = HOLD;
              hold_d  = HoldW'(RST_HOLD);
            end
          end
        end
        HOLD: begin
          if (hold_q == '0) begin
            state_d = RUN;
          end else begin
            hold_d = hold_q - HoldW'(1);
          end
        end
        RUN: begin
          if (memWrite && (Address == HALT_ADDR)) begin
            exit_code_d = writeData;
            state_d     = HALTED;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Registered from the next state so the core is released only on entry to RUN.
    cpu_reset_d = (state_d != RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      index_q     <= '0;
      count_q     <= '0;
      hold_q      <= '0;
      instwen_q   <= 1'b0;
      addwrite_q  <= 32'd0;
      data_q      <= 32'd0;
      cpu_reset_q <= 1'b1;
      exit_code_q <= 32'd0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      count_q     <= count_d;
      hold_q      <= hold_d;
      instwen_q   <= instwen_d;
      addwrite_q  <= addwrite_d;
      data_q      <= data_d;
      cpu_reset_q <= cpu_reset_d;
      exit_code_q <= exit_code_d;
      load_err_q  <= load_err_d;
    end
  end

endmodule
